// File: rtl/stage_complete_arb_pkg.sv
// Shared types for the multi-lane complete stage.
// Holds the FU result, ROB completion and CDB lane bundle types.
package stage_complete_arb_pkg;

  localparam int NUM_FU_DEF    = 4;
  localparam int CDB_WIDTH_DEF = 2;
  localparam int QDEPTH_DEF    = 2;

  localparam int TAG_W = 6;
  localparam int ROB_W = 5;

  typedef logic [TAG_W-1:0] TAG;
  typedef logic [ROB_W-1:0] ROB_IDX;

  typedef struct packed {
    logic        valid;
    TAG          dest_tag;
    ROB_IDX      rob_idx;
    logic [31:0] result;
    logic [31:0] rs2_value;
    logic        take_branch;
  } EX_IC_PACKET;

  typedef struct packed {
    logic        complete_en;
    ROB_IDX      complete_idx;
    logic [31:0] result;
    logic [31:0] rs2_value;
    logic        take_branch;
  } IC_ROB_PACKET;

  typedef struct packed {
    TAG   tag;
    logic en;
  } CDB_PACKET;

endpackage

// File: rtl/stage_complete_arb_fifo.sv
// complete_fifo: per-FU result queue, QDEPTH entries, squash clears it.
// Ports: clock, reset(n), squash, push/din, pop, head, empty, full.
module complete_fifo
  import stage_complete_arb_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        squash,
  input  logic        push,
  input  EX_IC_PACKET din,
  input  logic        pop,
  output EX_IC_PACKET head,
  output logic        empty,
  output logic        full
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [PW-1:0] LAST  = PW'(QDEPTH - 1);
  localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

  EX_IC_PACKET mem [2**PW];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_push = push && !full && !squash;
  assign do_pop  = pop && !empty && !squash;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (squash) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/stage_complete_arb.sv
// Complete stage: NUM_FU result FIFOs, round-robin onto CDB_WIDTH lanes.
// Ports: fu_valid/fu_packet/fu_ready in; cdb/cdb_en/ic_rob_packet out.
module stage_complete_arb
  import stage_complete_arb_pkg::*;
#(
  parameter int NUM_FU    = NUM_FU_DEF,
  parameter int CDB_WIDTH = CDB_WIDTH_DEF,
  parameter int QDEPTH    = QDEPTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  logic [NUM_FU-1:0]            fu_valid,
  input  EX_IC_PACKET [NUM_FU-1:0]     fu_packet,
  output logic [NUM_FU-1:0]            fu_ready,
  output TAG [CDB_WIDTH-1:0]           cdb,
  output logic [CDB_WIDTH-1:0]         cdb_en,
  output IC_ROB_PACKET [CDB_WIDTH-1:0] ic_rob_packet
);

  localparam int FW = $clog2(NUM_FU);
  localparam logic [FW-1:0] FU_LAST = FW'(NUM_FU - 1);

  EX_IC_PACKET [NUM_FU-1:0] head;
  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] grant;

  logic [FW-1:0] rr_q;
  logic [FW-1:0] rr_d;

  logic [CDB_WIDTH-1:0] lane_vld;
  logic [FW-1:0]        lane_src [CDB_WIDTH];

  CDB_PACKET    [CDB_WIDTH-1:0] lane_q;
  IC_ROB_PACKET [CDB_WIDTH-1:0] rob_q;

  function automatic logic [FW-1:0] nxt(input logic [FW-1:0] p);
    return (p == FU_LAST) ? '0 : p + 1'b1;
  endfunction

  assign fu_ready = ~full;
  assign push     = fu_valid & ~full & {NUM_FU{~squash}};

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
    complete_fifo #(
      .QDEPTH(QDEPTH)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .squash(squash),
      .push  (push[g]),
      .din   (fu_packet[g]),
      .pop   (grant[g]),
      .head  (head[g]),
      .empty (empty[g]),
      .full  (full[g])
    );
  end

  // Scan from rr_q, packing the first CDB_WIDTH non-empty heads into lanes.
  always_comb begin
    logic [FW-1:0] idx;
    logic [FW-1:0] last;
    logic          any;
    int            n;
    grant    = '0;
    lane_vld = '0;
    for (int k = 0; k < CDB_WIDTH; k++) lane_src[k] = '0;
    idx  = rr_q;
    last = rr_q;
    any  = 1'b0;
    n    = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      if (!empty[idx] && n < CDB_WIDTH) begin
        grant[idx] = 1'b1;
        last       = idx;
        any        = 1'b1;
        for (int k = 0; k < CDB_WIDTH; k++) begin
          if (n == k) begin
            lane_vld[k] = 1'b1;
            lane_src[k] = idx;
          end
        end
        n = n + 1;
      end
      idx = nxt(idx);
    end
    rr_d = any ? nxt(last) : rr_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q   <= '0;
      lane_q <= '0;
      rob_q  <= '0;
    end else if (squash) begin
      lane_q <= '0;
      rob_q  <= '0;
    end else begin
      rr_q <= rr_d;
      for (int k = 0; k < CDB_WIDTH; k++) begin
        if (lane_vld[k]) begin
          lane_q[k].en            <= 1'b1;
          lane_q[k].tag           <= head[lane_src[k]].dest_tag;
          rob_q[k].complete_en    <= 1'b1;
          rob_q[k].complete_idx   <= head[lane_src[k]].rob_idx;
          rob_q[k].result         <= head[lane_src[k]].result;
          rob_q[k].rs2_value      <= head[lane_src[k]].rs2_value;
          rob_q[k].take_branch    <= head[lane_src[k]].take_branch;
        end else begin
          lane_q[k] <= '0;
          rob_q[k]  <= '0;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < CDB_WIDTH; k++) begin
      cdb[k]    = lane_q[k].tag;
      cdb_en[k] = lane_q[k].en;
    end
  end

  assign ic_rob_packet = rob_q;

  // Producer valid bit travels with the payload but fu_valid decides.
  logic unused_valid;
  always_comb begin
    unused_valid = 1'b0;
    for (int g = 0; g < NUM_FU; g++) unused_valid ^= head[g].valid;
  end

endmodule

// File: tb/tb_stage_complete_arb.sv
// Directed bench for stage_complete_arb (NUM_FU=4, CDB_WIDTH=2, QDEPTH=2).
// Checks with immediate assertions; prints one summary line.
module tb_stage_complete_arb;
  import stage_complete_arb_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic                    squash = 1'b0;
  logic [3:0]              fu_valid = '0;
  EX_IC_PACKET [3:0]       fu_packet = '0;
  logic [3:0]              fu_ready;
  TAG [1:0]                cdb;
  logic [1:0]              cdb_en;
  IC_ROB_PACKET [1:0]      ic_rob_packet;

  int checks = 0;
  int errors = 0;

  stage_complete_arb #(
    .NUM_FU(4),
    .CDB_WIDTH(2),
    .QDEPTH(2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .squash       (squash),
    .fu_valid     (fu_valid),
    .fu_packet    (fu_packet),
    .fu_ready     (fu_ready),
    .cdb          (cdb),
    .cdb_en       (cdb_en),
    .ic_rob_packet(ic_rob_packet)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    fu_valid  = '0;
    fu_packet = '0;
    squash    = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic EX_IC_PACKET mk(input TAG t, input ROB_IDX r,
                                     input logic [31:0] res);
    EX_IC_PACKET p;
    p             = '0;
    p.valid       = 1'b0;
    p.dest_tag    = t;
    p.rob_idx     = r;
    p.result      = res;
    p.rs2_value   = ~res;
    p.take_branch = t[0];
    return p;
  endfunction

  TAG   seen_q [$];
  logic [3:0] acc;
  int   a_tag;
  int   b_tag;
  int   c_n;
  logic seen;

  initial begin
    // reset state
    do_reset;
    chk("rst_cdb_en", 80'(cdb_en), 80'h0);
    chk("rst_cdb", 80'(cdb), 80'h0);
    chk("rst_rob", 80'(ic_rob_packet[0]), 80'h0);
    chk("rst_ready", 80'(fu_ready), 80'hF);

    // single result, one-cycle latency
    fu_valid     = 4'b0001;
    fu_packet[0] = mk(6'd5, 5'd3, 32'hDEAD);
    step;
    fu_valid = '0;
    chk("single_e1_en", 80'(cdb_en), 80'h0);
    step;
    chk("single_en", 80'(cdb_en), 80'b01);
    chk("single_tag", 80'(cdb[0]), 80'd5);
    chk("single_idx", 80'(ic_rob_packet[0].complete_idx), 80'd3);
    chk("single_res", 80'(ic_rob_packet[0].result), 80'hDEAD);
    chk("single_rs2", 80'(ic_rob_packet[0].rs2_value), 80'hFFFF2152);
    chk("single_br", 80'(ic_rob_packet[0].take_branch), 80'd1);
    chk("single_cpl", 80'(ic_rob_packet[0].complete_en), 80'd1);
    chk("single_l1", 80'(ic_rob_packet[1]), 80'h0);
    step;
    chk("single_idle", 80'(cdb_en), 80'h0);

    // contention: four pushes, two lanes
    do_reset;
    fu_valid = 4'hF;
    for (int i = 0; i < 4; i++)
      fu_packet[i] = mk(TAG'(i + 1), ROB_IDX'(i + 8), 32'(i));
    step;
    fu_valid = '0;
    step;
    chk("cont1_en", 80'(cdb_en), 80'b11);
    chk("cont1_tags", 80'({cdb[1], cdb[0]}), 80'({6'd2, 6'd1}));
    step;
    chk("cont2_en", 80'(cdb_en), 80'b11);
    chk("cont2_tags", 80'({cdb[1], cdb[0]}), 80'({6'd4, 6'd3}));
    chk("cont_rr", 80'(dut.rr_q), 80'd0);
    step;
    chk("cont_idle", 80'(cdb_en), 80'h0);

    // backpressure on FU2 while FU0/FU1 saturate the lanes
    do_reset;
    a_tag = 1;
    b_tag = 40;
    c_n   = 0;
    seen_q.delete();
    for (int cyc = 0; cyc < 12; cyc++) begin
      fu_valid = '0;
      if (cyc < 4) fu_valid[1:0] = 2'b11;
      if (c_n < 3) fu_valid[2] = 1'b1;
      fu_packet[0] = mk(TAG'(a_tag), 5'd0, 32'h0);
      fu_packet[1] = mk(TAG'(b_tag), 5'd1, 32'h1);
      fu_packet[2] = mk(TAG'(20 + c_n), 5'd2, 32'(c_n));
      fu_packet[3] = '0;
      acc = fu_valid & fu_ready;
      step;
      if (acc[0]) a_tag++;
      if (acc[1]) b_tag++;
      if (acc[2]) c_n++;
      if (cyc == 1) chk("bp_full", 80'(fu_ready[2]), 80'd0);
      if (cyc == 2) chk("bp_rise", 80'(fu_ready[2]), 80'd1);
      for (int k = 0; k < 2; k++)
        if (cdb_en[k] && cdb[k] >= 20 && cdb[k] <= 22)
          seen_q.push_back(cdb[k]);
    end
    fu_valid = '0;
    chk("bp_accepted", 80'(c_n), 80'd3);
    chk("bp_count", 80'(seen_q.size()), 80'd3);
    if (seen_q.size() == 3) begin
      chk("bp_order", 80'({seen_q[0], seen_q[1], seen_q[2]}),
          80'({6'd20, 6'd21, 6'd22}));
    end

    // fairness: FU3 single push against busy FU0/FU1
    do_reset;
    a_tag = 1;
    b_tag = 40;
    seen  = 1'b0;
    fu_valid     = 4'b1011;
    fu_packet[3] = mk(6'd33, 5'd7, 32'h33);
    for (int cyc = 0; cyc < 4; cyc++) begin
      fu_packet[0] = mk(TAG'(a_tag), 5'd0, 32'h0);
      fu_packet[1] = mk(TAG'(b_tag), 5'd1, 32'h1);
      step;
      fu_valid[3] = 1'b0;
      a_tag++;
      b_tag++;
      for (int k = 0; k < 2; k++)
        if (cdb_en[k] && cdb[k] == 6'd33) seen = 1'b1;
    end
    fu_valid = '0;
    chk("fair_seen", 80'(seen), 80'd1);

    // squash with three queued packets
    do_reset;
    fu_valid     = 4'b0111;
    fu_packet[0] = mk(6'd11, 5'd1, 32'h11);
    fu_packet[1] = mk(6'd12, 5'd2, 32'h12);
    fu_packet[2] = mk(6'd13, 5'd3, 32'h13);
    step;
    fu_valid     = 4'b1000;
    fu_packet[3] = mk(6'd14, 5'd4, 32'h14);
    squash       = 1'b1;
    step;
    squash   = 1'b0;
    fu_valid = '0;
    chk("sq_en", 80'(cdb_en), 80'h0);
    chk("sq_ready", 80'(fu_ready), 80'hF);
    for (int cyc = 0; cyc < 4; cyc++) begin
      step;
      chk("sq_stale", 80'(cdb_en), 80'h0);
    end

    // async reset mid-stream
    do_reset;
    fu_valid     = 4'b0001;
    fu_packet[0] = mk(6'd9, 5'd9, 32'h99);
    step;
    fu_valid = '0;
    step;
    chk("ar_pre_en", 80'(cdb_en), 80'b01);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_en", 80'(cdb_en), 80'h0);
    chk("ar_cdb", 80'(cdb), 80'h0);
    chk("ar_rob", 80'(ic_rob_packet[0]), 80'h0);
    do_reset;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
